// File: rtl/wfg_mem_pkg.sv
// ---------------------------------------------------------------------------
// wfg_mem_pkg
// Shared definitions for the banked waveform memory merge:
//   - wb_state_t   : Wishbone port-0 FSM state encoding (IDLE/WAIT/ACK)
//   - bank_bits()  : width of a bank index (at least 1 bit, also for 1 bank)
//   - addr_bits()  : linear word-address width for NUM_BANKS macros
//   - slice_lo()   : low bit of slice idx inside a flattened per-bank bus
// ---------------------------------------------------------------------------
package wfg_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_t;

  // A single macro still needs a one-bit bank index so that buses keep a
  // legal width; the address space itself gains no extra bits in that case.
  function automatic int bank_bits(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int addr_bits(input int bank_aw, input int num_banks);
    return bank_aw + ((num_banks > 1) ? $clog2(num_banks) : 0);
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/wfg_mem_bank_mux.sv
// ---------------------------------------------------------------------------
// wfg_mem_bank_mux
// Registered bank select plus an N:1 read mux over the flattened macro data
// outputs. The bank index is captured in the same cycle the macros are
// strobed, so the mux selects the right macro when its data appears one
// cycle later. An out-of-range capture forces the output to zero.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   capture    in   load bank/oor registers this cycle
//   bank       in   [BW]   bank index of the current access
//   oor        in   bank index is out of range
//   bank_data  in   [NUM_BANKS*DW] flattened macro read data
//   dout       out  [DW]   selected read data (zero when out of range)
//   oor_q      out  registered out-of-range flag
// ---------------------------------------------------------------------------
module wfg_mem_bank_mux
  import wfg_mem_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int DW        = 32,
  parameter int BW        = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    capture,
  input  logic [BW-1:0]           bank,
  input  logic                    oor,
  input  logic [NUM_BANKS*DW-1:0] bank_data,
  output logic [DW-1:0]           dout,
  output logic                    oor_q
);

  logic [BW-1:0] bank_q;

  // Remember which macro was strobed; hold otherwise so the output keeps
  // following the last selected macro while it holds its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q <= '0;
      oor_q  <= 1'b0;
    end else if (capture) begin
      bank_q <= bank;
      oor_q  <= oor;
    end
  end

  // Plain compare-and-select mux; no index ever points past the bus even
  // when bank_q holds an unused code.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!oor_q && (bank_q == BW'(i))) begin
        dout = bank_data[slice_lo(i, DW) +: DW];
      end
    end
  end

endmodule

// File: rtl/wfg_mem_banked.sv
// ---------------------------------------------------------------------------
// wfg_mem_banked
// Joins NUM_BANKS 1RW/1R SRAM macros into one linear word space. Port 1 of
// every macro serves the waveform core read path; port 0 of every macro is
// driven from a Wishbone slave so firmware can load and read back tables.
//
// Optional feature (macro WFG_MEM_WB_ERR_EN): adds io_wbs_err, which pulses
// instead of io_wbs_ack for out-of-range Wishbone accesses.
//
// Ports:
//   io_wbs_clk     in   single clock for all logic and macro clocks
//   io_wbs_rst_n   in   synchronous active-low reset
//   io_wbs_cyc/stb/we/sel/adr/datwr  in   Wishbone request (adr is bytes)
//   io_wbs_datrd   out  [DW] Wishbone read data
//   io_wbs_ack     out  Wishbone acknowledge
//   io_wbs_err     out  Wishbone error (only with WFG_MEM_WB_ERR_EN)
//   csb1           in   core read enable, active-low
//   addr1          in   [AW] core word address
//   dout1          out  [DW] core read data, one cycle latency
//   mem_csb0/mem_web0/mem_wmask0/mem_addr0/mem_din0  out  per-bank port 0
//   mem_dout0      in   per-bank port-0 read data
//   mem_csb1/mem_addr1  out  per-bank port 1
//   mem_dout1      in   per-bank port-1 read data
// ---------------------------------------------------------------------------
module wfg_mem_banked
  import wfg_mem_pkg::*;
#(
  parameter int  NUM_BANKS = 2,
  parameter int  BANK_AW   = 9,
  parameter int  DW        = 32,
  localparam int BW        = bank_bits(NUM_BANKS),
  localparam int AW        = addr_bits(BANK_AW, NUM_BANKS)
) (
  input  logic                         io_wbs_clk,
  input  logic                         io_wbs_rst_n,
  input  logic                         io_wbs_cyc,
  input  logic                         io_wbs_stb,
  input  logic                         io_wbs_we,
  input  logic [DW/8-1:0]              io_wbs_sel,
  input  logic [31:0]                  io_wbs_adr,
  input  logic [DW-1:0]                io_wbs_datwr,
  output logic [DW-1:0]                io_wbs_datrd,
  output logic                         io_wbs_ack,
`ifdef WFG_MEM_WB_ERR_EN
  output logic                         io_wbs_err,
`endif
  input  logic                         csb1,
  input  logic [AW-1:0]                addr1,
  output logic [DW-1:0]                dout1,
  output logic [NUM_BANKS-1:0]         mem_csb0,
  output logic [NUM_BANKS-1:0]         mem_web0,
  output logic [NUM_BANKS*(DW/8)-1:0]  mem_wmask0,
  output logic [NUM_BANKS*BANK_AW-1:0] mem_addr0,
  output logic [NUM_BANKS*DW-1:0]      mem_din0,
  input  logic [NUM_BANKS*DW-1:0]      mem_dout0,
  output logic [NUM_BANKS-1:0]         mem_csb1,
  output logic [NUM_BANKS*BANK_AW-1:0] mem_addr1,
  input  logic [NUM_BANKS*DW-1:0]      mem_dout1
);

  localparam logic [BW:0] NB_LIMIT = (BW+1)'(NUM_BANKS);

  wb_state_t     state_q, state_d;
  logic          wb_req;
  logic          wb_capture;
  logic [AW-1:0] wb_word;
  logic [BW-1:0] wb_bank;
  logic [BW-1:0] core_bank;
  logic          wb_oor;
  logic          core_oor;
  logic          wb_oor_q;
  logic          core_oor_q;
  logic          we_q;
  logic [DW-1:0] wb_rd_data;
  logic          unused_bits;

  assign wb_req     = io_wbs_cyc & io_wbs_stb;
  assign wb_capture = (state_q == IDLE) & wb_req;
  assign wb_word    = io_wbs_adr[AW+1:2];

  // With a single macro there are no bank bits in the address at all.
  generate
    if (NUM_BANKS > 1) begin : g_bank_sel
      assign wb_bank   = wb_word[AW-1:BANK_AW];
      assign core_bank = addr1[AW-1:BANK_AW];
    end else begin : g_single_bank
      assign wb_bank   = '0;
      assign core_bank = '0;
    end
  endgenerate

  // Non-power-of-two bank counts leave codes with no macro behind them.
  assign wb_oor   = ({1'b0, wb_bank}   >= NB_LIMIT);
  assign core_oor = ({1'b0, core_bank} >= NB_LIMIT);

  // Address/data/mask are broadcast; only the chip selects steer the access.
  // Reset forces every core-port chip select high regardless of csb1.
  generate
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank_bus
      assign mem_addr1[slice_lo(i, BANK_AW) +: BANK_AW] = addr1[BANK_AW-1:0];
      assign mem_csb1[i] = ~io_wbs_rst_n | csb1 | core_oor | (core_bank != BW'(i));
      assign mem_addr0[slice_lo(i, BANK_AW) +: BANK_AW] = wb_word[BANK_AW-1:0];
      assign mem_wmask0[slice_lo(i, DW/8) +: DW/8]      = io_wbs_sel;
      assign mem_din0[slice_lo(i, DW) +: DW]            = io_wbs_datwr;
    end
  endgenerate

  wfg_mem_bank_mux #(
    .NUM_BANKS (NUM_BANKS),
    .DW        (DW),
    .BW        (BW)
  ) u_core_mux (
    .clk       (io_wbs_clk),
    .rst_n     (io_wbs_rst_n),
    .capture   (~csb1),
    .bank      (core_bank),
    .oor       (core_oor),
    .bank_data (mem_dout1),
    .dout      (dout1),
    .oor_q     (core_oor_q)
  );

  wfg_mem_bank_mux #(
    .NUM_BANKS (NUM_BANKS),
    .DW        (DW),
    .BW        (BW)
  ) u_wb_mux (
    .clk       (io_wbs_clk),
    .rst_n     (io_wbs_rst_n),
    .capture   (wb_capture),
    .bank      (wb_bank),
    .oor       (wb_oor),
    .bank_data (mem_dout0),
    .dout      (wb_rd_data),
    .oor_q     (wb_oor_q)
  );

  // Wishbone FSM state register.
  always_ff @(posedge io_wbs_clk) begin
    if (!io_wbs_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one strobe cycle, one cycle for macro data, one ack cycle.
  // Dropping cyc in WAIT abandons the transfer; a write already committed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wb_req) state_d = WAIT;
      WAIT:    state_d = io_wbs_cyc ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: port-0 strobes only in the request cycle and never in reset;
  // ack (or err) is a Moore output of the ACK state.
  always_comb begin
    mem_csb0 = '1;
    mem_web0 = '1;
    if (io_wbs_rst_n && wb_capture && !wb_oor) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (wb_bank == BW'(i)) begin
          mem_csb0[i] = 1'b0;
          mem_web0[i] = ~io_wbs_we;
        end
      end
    end
`ifdef WFG_MEM_WB_ERR_EN
    io_wbs_ack = (state_q == ACK) & ~wb_oor_q;
    io_wbs_err = (state_q == ACK) &  wb_oor_q;
`else
    io_wbs_ack = (state_q == ACK);
`endif
  end

  // Direction of the transfer in flight, needed once the request is gone.
  always_ff @(posedge io_wbs_clk) begin
    if (!io_wbs_rst_n) begin
      we_q <= 1'b0;
    end else if (wb_capture) begin
      we_q <= io_wbs_we;
    end
  end

  // Read data is taken from the macro in WAIT and presented with the ack;
  // writes and abandoned transfers leave the previous value in place.
  always_ff @(posedge io_wbs_clk) begin
    if (!io_wbs_rst_n) begin
      io_wbs_datrd <= '0;
    end else if ((state_q == WAIT) && io_wbs_cyc && !we_q) begin
      io_wbs_datrd <= wb_rd_data;
    end
  end

  assign unused_bits = ^{io_wbs_adr[31:AW+2], io_wbs_adr[1:0], core_oor_q, wb_oor_q};

endmodule

// File: doc/wfg_mem_banked.md
Name: wfg_mem_banked

Overview:
- Parametrised successor to the two-bank memory merge. Joins NUM_BANKS single-port-1RW/1R SRAM macros (sky130 32x512 class) into one linear word space.
- Provides two access paths:
  - waveform-core read port (port 1 of every macro), for the pattern/sample fetch;
  - Wishbone slave on port 0 of every macro, so firmware can load and read back waveform tables. This fills the currently unconnected port 0.
- Sits between wfg_top / the Wishbone bus and the SRAM macros.

Parameters:
- NUM_BANKS, 2, number of SRAM macros; 1..8.
- BANK_AW, 9, word-address width of one macro.
- DW, 32, data width; multiple of 8.
- AW, BANK_AW+$clog2(NUM_BANKS) (derived, localparam), linear word-address width.

Ports:
- io_wbs_clk  in  1  single clock for all logic and all macro clk0/clk1.
- io_wbs_rst_n  in  1  reset; synchronous, active-low.
- io_wbs_cyc  in  1  Wishbone cycle.
- io_wbs_stb  in  1  Wishbone strobe (already address-decoded upstream).
- io_wbs_we  in  1  write enable.
- io_wbs_sel  in  DW/8  byte selects.
- io_wbs_adr  in  32  byte address; word address = io_wbs_adr[AW+1:2].
- io_wbs_datwr  in  DW  write data.
- io_wbs_datrd  out  DW  read data.
- io_wbs_ack  out  1  acknowledge.
- csb1  in  1  core read enable, active-low.
- addr1  in  AW  core word address.
- dout1  out  DW  core read data.
- mem_csb0/mem_web0  out  NUM_BANKS  per-bank port-0 chip select / write-enable, active-low.
- mem_wmask0  out  NUM_BANKS*DW/8  per-bank byte mask.
- mem_addr0  out  NUM_BANKS*BANK_AW  per-bank port-0 address.
- mem_din0  out  NUM_BANKS*DW  per-bank write data.
- mem_dout0  in  NUM_BANKS*DW  per-bank port-0 read data.
- mem_csb1  out  NUM_BANKS  per-bank port-1 chip select.
- mem_addr1  out  NUM_BANKS*BANK_AW  per-bank port-1 address.
- mem_dout1  in  NUM_BANKS*DW  per-bank port-1 read data.

Behaviour:
- Bank index = address[AW-1:BANK_AW]. In-bank address = address[BANK_AW-1:0]. Bank i occupies words i*2^BANK_AW upward.
- Reset values: io_wbs_ack=0, io_wbs_datrd=0, FSM=IDLE, rd_bank_q=0, wb_bank_q=0.
- Reset effect on macro strobes: all mem_csb0/mem_csb1=1 and mem_web0=1 for as long as rst_n=0, regardless of csb1.

Core read path (port 1):
- mem_csb1[i] = csb1 | (bank!=i), combinational. mem_addr1 = addr1[BANK_AW-1:0] broadcast to all banks.
- rd_bank_q <= bank on every cycle with csb1=0. It holds when csb1=1.
- dout1 = mem_dout1 slice rd_bank_q. Latency 1 cycle, matching the macro.
- Out-of-range bank (>=NUM_BANKS): no csb asserted; dout1=0 on the next cycle, via a registered oor flag.

Wishbone FSM (port 0):
- IDLE:
  - When cyc&stb, drive mem_csb0[bank]=0, mem_web0[bank]=~we, wmask=sel, addr, din, for that single cycle.
  - Latch wb_bank_q and an oor flag; go to WAIT.
- WAIT: all port-0 strobes inactive. io_wbs_datrd <= read ? (oor ? 0 : mem_dout0[wb_bank_q]) : hold. Go to ACK.
- ACK: io_wbs_ack=1 for exactly one cycle; go to IDLE. Ack latency = 2 cycles after stb sampled.
- cyc deasserted in WAIT: go to IDLE, no ack. The macro write has already committed.
- stb still high in the cycle after ACK: treated as a new transfer; no back-to-back within ACK.
- Out-of-range write: dropped, still acked. Out-of-range read: returns 0.
- Port-0 write and port-1 read of the same word in the same cycle: no forwarding; port-1 data is undefined for that cycle.
- Different words: fully concurrent.

Optional Feature:
- Macro: WFG_MEM_WB_ERR_EN.
- Defined:
  - Adds output io_wbs_err (1 bit, reset 0).
  - Out-of-range Wishbone access pulses io_wbs_err in the ACK cycle instead of io_wbs_ack.
  - Write still dropped; datrd=0.
- Undefined: no err port; out-of-range behaves as above, acked.

Decomposition:
- Package wfg_mem_pkg:
  - FSM state encoding (IDLE/WAIT/ACK);
  - localparam helpers for AW;
  - slice-index functions for the flattened bank buses.
- Sub-module wfg_mem_bank_mux: registered bank-select plus DW-wide N:1 read mux with oor zeroing. Instantiated twice: core path and Wishbone path.

Test Plan:
- Wishbone write 0xDEADBEEF at byte 0x0000_0804 (word 0x201, bank1 addr 1), sel=4'hF:
  - mem_csb0=2'b01 and mem_web0[1]=0 for one cycle;
  - ack exactly 2 cycles after stb.
  - Then core read addr1=0x201 -> dout1=0xDEADBEEF one cycle later.
- Byte-masked write sel=4'b0010 of 0x0000AB00 over 0xDEADBEEF at word 0x005 -> Wishbone read returns 0xDEADABEF.
- Core back-to-back reads addr1=0x000, 0x200, 0x001 with csb1 low:
  - dout1 follows bank0/bank1/bank0 data with 1-cycle latency;
  - csb1 high afterwards -> dout1 holds last bank selection.
- NUM_BANKS=3, read word 0x600 (bank3, OOR):
  - no mem_csb asserted, datrd=0, ack;
  - with WFG_MEM_WB_ERR_EN: err=1, ack=0.
- cyc dropped in WAIT during a write -> no ack, FSM IDLE next cycle, data present in the macro on readback.
- rst_n=0 asserted in WAIT -> next cycle ack=0, all csb=1, FSM IDLE. A following transfer completes normally.
